// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data LSB first, optional parity, 1-2 stop bits.
// A one-entry holding register in front of the shifter lets frames run back-to-back.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_serial,
  output logic                 o_tx_active,
  output logic                 o_tx_done,
  output logic [2:0]           o_dbg_state
);

  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, serial_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic                 accept;
  logic                 load;
  logic                 done;

  // Handshake: a word transfers on a rising edge where i_valid && o_ready;
  // o_ready is simply "holding register empty", so it never depends on i_valid.
  assign accept = i_valid && !hold_full_q;

  // serial_d is the line level for the state being entered, so the pad stays registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    load     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        if (hold_full_q) begin
          load     = 1'b1;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = DATA;
          cnt_d    = '0;
          bit_d    = '0;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != 0) begin
              state_d  = PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = STOP;
          cnt_d    = '0;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          done  = 1'b1;
          cnt_d = '0;
          if (hold_full_q) begin
            load     = 1'b1;
            state_d  = START;
            serial_d = 1'b0;
          end else begin
            state_d  = IDLE;
            serial_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        bit_d    = '0;
        serial_d = 1'b1;
      end
    endcase

    // Parity is taken from the word as it enters the shifter, never from live i_data.
    if (load) begin
      shift_d = hold_q;
      par_d   = (PARITY_MODE == 2) ? ~(^hold_q) : (^hold_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      serial_q    <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      // accept needs an empty hold and load needs a full one, so they never coincide.
      if (accept) begin
        hold_q      <= i_data;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign o_ready     = !hold_full_q;
  assign o_serial    = serial_q;
  assign o_tx_active = (state_q != IDLE);
  assign o_tx_done   = done;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (default, 7O2, 5N1 at 2 clk/bit) driven one at a time
// through a shared driver; a line monitor compares each frame against a slot-level model.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  int         sel = 0;
  logic [8:0] d_data;
  logic       d_valid;
  logic [2:0] idle_code;

  int cfg_cpb[3] = '{87, 87, 2};
  int cfg_db[3]  = '{8, 7, 5};
  int cfg_pm[3]  = '{1, 2, 0};
  int cfg_sb[3]  = '{1, 2, 1};

  logic [2:0] rdy, ser, act, dn;
  logic [2:0] st0, st1, st2;

  uart_tx_param u_def (
    .clk(clk), .reset(reset), .i_data(d_data[7:0]), .i_valid(d_valid && (sel == 0)),
    .o_ready(rdy[0]), .o_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]),
    .o_dbg_state(st0)
  );

  uart_tx_param #(.CLKS_PER_BIT(87), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_odd (
    .clk(clk), .reset(reset), .i_data(d_data[6:0]), .i_valid(d_valid && (sel == 1)),
    .o_ready(rdy[1]), .o_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]),
    .o_dbg_state(st1)
  );

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1)) u_small (
    .clk(clk), .reset(reset), .i_data(d_data[4:0]), .i_valid(d_valid && (sel == 2)),
    .o_ready(rdy[2]), .o_serial(ser[2]), .o_tx_active(act[2]), .o_tx_done(dn[2]),
    .o_dbg_state(st2)
  );

  logic o_rdy, o_ser, o_act, o_dn;
  logic [2:0] o_st;
  always_comb begin
    o_rdy = rdy[sel];
    o_ser = ser[sel];
    o_act = act[sel];
    o_dn  = dn[sel];
    case (sel)
      1:       o_st = st1;
      2:       o_st = st2;
      default: o_st = st0;
    endcase
  end

  logic [8:0]  exp_q[$];
  int unsigned start_q[$];

  // Line level of frame slot `slot` (start, data LSB first, parity if any, stops).
  function automatic logic model_bit(input int s, input logic [8:0] w, input int slot);
    int   db = cfg_db[s];
    logic p  = 1'b0;
    if (slot == 0) return 1'b0;
    if (slot <= db) return w[slot-1];
    for (int i = 0; i < db; i++) p = p ^ w[i];
    if (cfg_pm[s] != 0 && slot == db + 1) return (cfg_pm[s] == 2) ? ~p : p;
    return 1'b1;
  endfunction

  function automatic int frame_len(input int s);
    return (1 + cfg_db[s] + ((cfg_pm[s] != 0) ? 1 : 0) + cfg_sb[s]) * cfg_cpb[s];
  endfunction

  function automatic logic [8:0] rand_word(input int s);
    return 9'($urandom_range(0, (1 << cfg_db[s]) - 1));
  endfunction

  task automatic drive_words(input logic [8:0] words[$], input int max_gap);
    foreach (words[i]) begin
      int guard = 0;
      d_valid = 1'b1;
      d_data  = words[i];
      while (!o_rdy && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      compared++;
      if (!o_rdy) begin
        mismatched++;
        $display("FAIL accept_timeout: o_ready=%b after %0d cycles, required 1", o_rdy, guard);
      end else begin
        exp_q.push_back(words[i]);
      end
      @(negedge clk);
      if (max_gap > 0) begin
        d_valid = 1'b0;
        d_data  = 9'($urandom);
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
      end
    end
    d_valid = 1'b0;
  endtask

  task automatic watch(input int nframes);
    int s   = sel;
    int cpb = cfg_cpb[s];
    int f   = frame_len(s);
    for (int k = 0; k < nframes; k++) begin
      int wait_n = 0, bad_idle = 0, bad_line = 0, bad_done = 0, bad_act = 0;
      logic [8:0] w;
      logic [8:0] got = '0;
      while (o_ser !== 1'b0 && wait_n < 20000) begin
        if (o_act !== 1'b0 || o_dn !== 1'b0) bad_idle++;
        @(negedge clk);
        wait_n++;
      end
      compared++;
      if (o_ser !== 1'b0) begin
        mismatched++;
        $display("FAIL frame_start s=%0d k=%0d: line=%b after %0d cycles, required start bit 0", s, k, o_ser, wait_n);
        return;
      end
      compared++;
      if (bad_idle !== 0) begin
        mismatched++;
        $display("FAIL idle_flags s=%0d k=%0d: %0d idle cycles with active/done set, required 0", s, k, bad_idle);
      end
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_frame s=%0d k=%0d: frame started with 0 words queued, required >=1", s, k);
        return;
      end
      w = exp_q.pop_front();
      start_q.push_back(cyc);
      for (int t = 0; t < f; t++) begin
        int slot = t / cpb;
        if (o_ser !== model_bit(s, w, slot)) bad_line++;
        if (o_dn !== (t == f - 1)) bad_done++;
        if (o_act !== 1'b1 || o_st === idle_code) bad_act++;
        if ((t % cpb) == cpb / 2 && slot >= 1 && slot <= cfg_db[s]) got[slot-1] = o_ser;
        @(negedge clk);
      end
      compared++;
      if (bad_line !== 0) begin
        mismatched++;
        $display("FAIL line_shape s=%0d word=%h: %0d cycles off, required 0", s, w, bad_line);
      end
      compared++;
      if (bad_done !== 0) begin
        mismatched++;
        $display("FAIL done_pulse s=%0d word=%h: %0d cycles off, required 0", s, w, bad_done);
      end
      compared++;
      if (bad_act !== 0) begin
        mismatched++;
        $display("FAIL active s=%0d word=%h: %0d cycles inactive, required 0", s, w, bad_act);
      end
      compared++;
      if (got !== w) begin
        mismatched++;
        $display("FAIL decoded s=%0d: got %h, required %h", s, got, w);
      end
    end
  endtask

  task automatic check_idle(input string name);
    compared++;
    if (o_ser !== 1'b1 || o_act !== 1'b0 || o_rdy !== 1'b1 || o_dn !== 1'b0) begin
      mismatched++;
      $display("FAIL %s: ser/act/rdy/done=%b%b%b%b, required 1010", name, o_ser, o_act, o_rdy, o_dn);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset   = 1'b1;
    d_valid = 1'b0;
    d_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sel   = 0;
    idle_code = o_st;
    compared++;
    if (ser !== 3'b111) begin mismatched++; $display("FAIL reset_serial: %b, required 111", ser); end
    compared++;
    if (rdy !== 3'b111) begin mismatched++; $display("FAIL reset_ready: %b, required 111", rdy); end
    compared++;
    if (act !== 3'b000) begin mismatched++; $display("FAIL reset_active: %b, required 000", act); end
    compared++;
    if (dn !== 3'b000) begin mismatched++; $display("FAIL reset_done: %b, required 000", dn); end
    for (int i = 0; i < 300; i++) begin
      d_data = 9'($urandom);
      if (ser !== 3'b111 || rdy !== 3'b111 || act !== 3'b000 || dn !== 3'b000 ||
          st0 !== idle_code || st1 !== idle_code || st2 !== idle_code) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL reset_hold: %0d bad idle cycles, required 0", bad); end
  endtask

  task automatic test_default_a5();
    sel = 0;
    exp_q.push_back(9'h0A5);
    d_valid = 1'b1;
    d_data  = 9'h0A5;
    @(negedge clk);
    d_valid = 1'b0;
    d_data  = 9'h1FF;
    compared++;
    if (o_rdy !== 1'b0 || o_ser !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_accept: ready=%b ser=%b, required 0 1", o_rdy, o_ser);
    end
    @(negedge clk);
    compared++;
    if (o_ser !== 1'b0 || o_rdy !== 1'b1 || o_act !== 1'b1) begin
      mismatched++;
      $display("FAIL latency_start: ser=%b ready=%b act=%b, required 0 1 1", o_ser, o_rdy, o_act);
    end
    watch(1);
    check_idle("after_a5");
  endtask

  task automatic test_parity_odd();
    logic [8:0] q[$];
    sel = 1;
    q.push_back(9'h055);
    repeat (3) q.push_back(rand_word(1));
    fork
      drive_words(q, 40);
      watch(4);
    join
    check_idle("after_odd");
  endtask

  task automatic test_back_to_back();
    logic [8:0] q[$];
    int f = frame_len(0);
    sel = 0;
    start_q.delete();
    q.push_back(9'h001);
    q.push_back(9'h002);
    q.push_back(9'h003);
    fork
      drive_words(q, 0);
      watch(3);
    join
    for (int i = 1; i < start_q.size(); i++) begin
      compared++;
      if (start_q[i] - start_q[i-1] !== f) begin
        mismatched++;
        $display("FAIL b2b_spacing frame %0d: %0d cycles, required %0d", i, start_q[i] - start_q[i-1], f);
      end
    end
    check_idle("after_b2b");
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    int bad   = 0;
    sel = 0;
    d_valid = 1'b1;
    d_data  = rand_word(0);
    @(negedge clk);
    d_data = 9'h03C;
    while (!o_rdy && guard < 5000) begin @(negedge clk); guard++; end
    @(negedge clk);
    d_valid = 1'b0;
    repeat (87 + 250) @(negedge clk);
    compared++;
    if (o_rdy !== 1'b0 || o_act !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_frame_setup: ready=%b act=%b, required 0 1", o_rdy, o_act);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_mid_frame");
    reset = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (o_ser !== 1'b1 || o_dn !== 1'b0 || o_act !== 1'b0 || o_rdy !== 1'b1) bad++;
      @(negedge clk);
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("FAIL after_reset_quiet: %0d bad cycles, required 0", bad); end
  endtask

  task automatic test_small();
    logic [8:0] q[$];
    sel = 2;
    q.push_back(9'h01F);
    repeat (8) q.push_back(rand_word(2));
    fork
      drive_words(q, 5);
      watch(9);
    join
    check_idle("after_small");
  endtask

  task automatic test_random_default();
    logic [8:0] q[$];
    sel = 0;
    repeat (5) q.push_back(rand_word(0));
    fork
      drive_words(q, 30);
      watch(5);
    join
    check_idle("after_random");
  endtask

  initial begin
    test_reset();
    test_default_a5();
    test_parity_odd();
    test_back_to_back();
    test_reset_mid_frame();
    test_small();
    test_random_default();
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL leftover_words: %0d queued, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
